bg_stream_reader: RTL and testbench
===================================

// Module: bg_stream_reader
// PURPOSE
//  Read side of the background frame store, paired with the adaptive background updater.
//  Turns the camera pixel stream into per-pixel frame addresses and issues background RAM reads.
//  Emits {addr, live, bg, active, load} aligned for the updater's addr_in/live/bg/active/load inputs.
//  Snoops the updater's write port and forwards in-flight writes so bg_out never returns stale data.
// PARAMETERS
//  ADDR_WIDTH   17     frame-store address width
//  PIXEL_WIDTH  16     RGB565 pixel width
//  RAM_LAT      2      background RAM read latency in cycles (1..4); read-first on same-address write
//  FRAME_PIXELS 76800  pixels per frame (320x240); address wraps after FRAME_PIXELS-1
// PORTS
//  clk          in   1           clock
//  rst          in   1           reset, synchronous, active-high
//  enable       in   1           gates pixel acceptance only; pipeline always advances
//  frame_start  in   1           one-cycle pulse at start of frame (vsync edge)
//  pix_valid    in   1           live pixel present this cycle
//  pix_data     in   PIXEL_WIDTH live RGB565 pixel
//  load_in      in   1           manual background-load request, travels with the pixel
//  ram_rd_en    out  1           RAM read strobe (combinational)
//  ram_rd_addr  out  ADDR_WIDTH  RAM read address (combinational)
//  ram_rd_data  in   PIXEL_WIDTH RAM data, valid RAM_LAT cycles after ram_rd_en
//  wr_en        in   1           snooped background write enable (from updater)
//  wr_addr      in   ADDR_WIDTH  snooped write address
//  wr_data      in   PIXEL_WIDTH snooped write data
//  addr_out     out  ADDR_WIDTH  aligned pixel address
//  live_out     out  PIXEL_WIDTH aligned live pixel
//  bg_out       out  PIXEL_WIDTH aligned background pixel (forwarded if hit)
//  active_out   out  1           one-cycle strobe: aligned outputs valid
//  load_out     out  1           load_in delayed with the pixel
//  frame_done   out  1           asserted with active_out for address FRAME_PIXELS-1
// BEHAVIOUR
//  - Reset: all outputs 0, addr counter 0, all stage valid/hit flags cleared; in-flight pixels dropped.
//  - Accept: accept = enable & pix_valid. On accept, ram_rd_en=1, ram_rd_addr = frame_start ? 0 : cnt.
//  - Counter: on accept cnt <= (issued addr == FRAME_PIXELS-1) ? 0 : issued addr+1;
//    frame_start without accept sets cnt <= 0; enable=0 holds cnt.
//  - Delay line: RAM_LAT stages of {valid, addr, live, load, hit, fwd_data}; stage 0 loaded on accept.
//  - Forwarding: each cycle, for every valid stage (including the one loaded this cycle) with
//    wr_en & wr_addr==stage addr: hit<=1, fwd_data<=wr_data; a later write overwrites an earlier one.
//  - Output: pixel accepted at cycle T appears on registered outputs at T+RAM_LAT;
//    bg_out = hit ? fwd_data : ram_rd_data.
//    active_out pulses one cycle; when not valid, addr/live/bg_out hold their last values and
//    load_out=frame_done=0.
//  - Writes at T..T+RAM_LAT-1 are forwarded; a write in the output cycle itself is not.
//  - Throughput: one pixel per cycle, no backpressure; back-to-back accepts fully pipelined.
//  - frame_start mid-frame: new pixel gets addr 0; pixels already in flight complete unchanged.
//  - Widths: address compare is full ADDR_WIDTH; FRAME_PIXELS must be <= 2**ADDR_WIDTH.
// TESTING
//  1. rst held 3 cycles mid-stream -> all outputs 0 next cycle, no active_out for flushed pixels.
//  2. RAM mem[a]=a*3, RAM_LAT=2, frame_start+4 accepts at T..T+3 -> active_out T+2..T+5,
//     addr_out 0..3, bg_out 0,3,6,9, live_out matches pix_data.
//  3. FRAME_PIXELS=8, 10 accepts -> addr_out 0..7,0,1; frame_done only with addr 7.
//  4. addr 5 accepted at T, wr 5<-16'hABCD at T+1 -> bg_out=16'hABCD;
//     writes 16'h1111 at T, 16'h2222 at T+1 -> bg_out=16'h2222.
//  5. frame_start with accept at addr 37 -> that pixel addr_out=0, next=1; in-flight 35,36 unaffected.
//  6. enable=0 with pix_valid=1 for 5 cycles -> ram_rd_en=0, no active_out, cnt resumes unchanged.

Source files
------------

// File: rtl/bg_stream_reader.sv
// Read side of the background frame store: numbers incoming pixels, issues background RAM
// reads and re-aligns pixel, address and background (with write forwarding) for the updater.
module bg_stream_reader #(
  parameter int ADDR_WIDTH   = 17,
  parameter int PIXEL_WIDTH  = 16,
  parameter int RAM_LAT      = 2,
  parameter int FRAME_PIXELS = 76800
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   frame_start,
  input  logic                   pix_valid,
  input  logic [PIXEL_WIDTH-1:0] pix_data,
  input  logic                   load_in,
  output logic                   ram_rd_en,
  output logic [ADDR_WIDTH-1:0]  ram_rd_addr,
  input  logic [PIXEL_WIDTH-1:0] ram_rd_data,
  input  logic                   wr_en,
  input  logic [ADDR_WIDTH-1:0]  wr_addr,
  input  logic [PIXEL_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0]  addr_out,
  output logic [PIXEL_WIDTH-1:0] live_out,
  output logic [PIXEL_WIDTH-1:0] bg_out,
  output logic                   active_out,
  output logic                   load_out,
  output logic                   frame_done
);

  localparam int LAST = RAM_LAT - 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_PIXELS - 1);

  logic                   accept;
  logic [ADDR_WIDTH-1:0]  issuedAddr;
  logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;

  logic                   stgValid_q [RAM_LAT];
  logic [ADDR_WIDTH-1:0]  stgAddr_q  [RAM_LAT];
  logic [PIXEL_WIDTH-1:0] stgLive_q  [RAM_LAT];
  logic                   stgLoad_q  [RAM_LAT];
  logic                   stgHit_q   [RAM_LAT];
  logic [PIXEL_WIDTH-1:0] stgFwd_q   [RAM_LAT];

  logic                   stgValid_d [RAM_LAT];
  logic [ADDR_WIDTH-1:0]  stgAddr_d  [RAM_LAT];
  logic [PIXEL_WIDTH-1:0] stgLive_d  [RAM_LAT];
  logic                   stgLoad_d  [RAM_LAT];
  logic                   stgHit_d   [RAM_LAT];
  logic [PIXEL_WIDTH-1:0] stgFwd_d   [RAM_LAT];

  logic [ADDR_WIDTH-1:0]  holdAddr_q;
  logic [PIXEL_WIDTH-1:0] holdLive_q;
  logic [PIXEL_WIDTH-1:0] holdBg_q;

  logic                   lastValid;
  logic [PIXEL_WIDTH-1:0] bgNow;

  // Reset suppresses acceptance so no read is issued while the pipeline is being flushed.
  assign accept      = enable & pix_valid & ~rst;
  assign issuedAddr  = frame_start ? '0 : cnt_q;
  assign ram_rd_en   = accept;
  assign ram_rd_addr = issuedAddr;

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = (issuedAddr == LAST_ADDR) ? '0 : issuedAddr + ADDR_WIDTH'(1);
    end else if (frame_start) begin
      cnt_d = '0;
    end
  end

  // Shift the delay line, then let this cycle's snooped write claim any entry whose address
  // matches; the entry is checked at its next position so the latest write always wins.
  always_comb begin
    stgValid_d[0] = accept;
    stgAddr_d[0]  = issuedAddr;
    stgLive_d[0]  = pix_data;
    stgLoad_d[0]  = load_in;
    stgHit_d[0]   = 1'b0;
    stgFwd_d[0]   = '0;
    for (int k = 1; k < RAM_LAT; k++) begin
      stgValid_d[k] = stgValid_q[k-1];
      stgAddr_d[k]  = stgAddr_q[k-1];
      stgLive_d[k]  = stgLive_q[k-1];
      stgLoad_d[k]  = stgLoad_q[k-1];
      stgHit_d[k]   = stgHit_q[k-1];
      stgFwd_d[k]   = stgFwd_q[k-1];
    end
    for (int k = 0; k < RAM_LAT; k++) begin
      if (stgValid_d[k] && wr_en && (wr_addr == stgAddr_d[k])) begin
        stgHit_d[k] = 1'b1;
        stgFwd_d[k] = wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      for (int k = 0; k < RAM_LAT; k++) begin
        stgValid_q[k] <= 1'b0;
        stgAddr_q[k]  <= '0;
        stgLive_q[k]  <= '0;
        stgLoad_q[k]  <= 1'b0;
        stgHit_q[k]   <= 1'b0;
        stgFwd_q[k]   <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      for (int k = 0; k < RAM_LAT; k++) begin
        stgValid_q[k] <= stgValid_d[k];
        stgAddr_q[k]  <= stgAddr_d[k];
        stgLive_q[k]  <= stgLive_d[k];
        stgLoad_q[k]  <= stgLoad_d[k];
        stgHit_q[k]   <= stgHit_d[k];
        stgFwd_q[k]   <= stgFwd_d[k];
      end
    end
  end

  // The last stage lines up with the RAM data; between pixels the outputs replay the hold copy.
  assign lastValid = stgValid_q[LAST];
  assign bgNow     = stgHit_q[LAST] ? stgFwd_q[LAST] : ram_rd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      holdAddr_q <= '0;
      holdLive_q <= '0;
      holdBg_q   <= '0;
    end else if (lastValid) begin
      holdAddr_q <= stgAddr_q[LAST];
      holdLive_q <= stgLive_q[LAST];
      holdBg_q   <= bgNow;
    end
  end

  assign active_out = lastValid;
  assign addr_out   = lastValid ? stgAddr_q[LAST] : holdAddr_q;
  assign live_out   = lastValid ? stgLive_q[LAST] : holdLive_q;
  assign bg_out     = lastValid ? bgNow : holdBg_q;
  assign load_out   = lastValid & stgLoad_q[LAST];
  assign frame_done = lastValid & (stgAddr_q[LAST] == LAST_ADDR);

endmodule

// File: tb/tb_bg_stream_reader.sv
// Directed bench for bg_stream_reader: a full-size-frame instance (64 pixels) and a tiny-frame
// instance (8 pixels) share stimulus; each has its own RAM model returning mem[a] = a*3.
module tb_bg_stream_reader;

  localparam int AW = 17;
  localparam int PW = 16;

  typedef struct {
    logic          fs;
    logic          valid;
    logic          en;
    logic          load;
    logic [PW-1:0] pix;
    logic          wrEn;
    logic [AW-1:0] wrAddr;
    logic [PW-1:0] wrData;
    logic          expRdEn;
    logic [AW-1:0] expRdAddr;
    logic          expActive;
    logic [AW-1:0] expAddr;
    logic [PW-1:0] expLive;
    logic [PW-1:0] expBg;
    logic          expLoad;
    logic          expDone;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable, frameStart, pixValid, loadIn, wrEn;
  logic [PW-1:0] pixData, wrData;
  logic [AW-1:0] wrAddr;

  logic          rdEnA, rdEnB;
  logic [AW-1:0] rdAddrA, rdAddrB;
  logic [PW-1:0] rdDataA, rdDataB;
  logic [AW-1:0] addrA, addrB;
  logic [PW-1:0] liveA, liveB, bgA, bgB;
  logic          activeA, activeB, loadA, loadB, doneA, doneB;

  logic [PW-1:0] pipeA [2];
  logic [PW-1:0] pipeB [2];

  int checkCount = 0;
  int passCount  = 0;

  vec_t vecs [30];

  always #5 clk = ~clk;

  bg_stream_reader #(.ADDR_WIDTH(AW), .PIXEL_WIDTH(PW), .RAM_LAT(2), .FRAME_PIXELS(64)) dutA (
    .clk(clk), .rst(rst), .enable(enable), .frame_start(frameStart), .pix_valid(pixValid),
    .pix_data(pixData), .load_in(loadIn), .ram_rd_en(rdEnA), .ram_rd_addr(rdAddrA),
    .ram_rd_data(rdDataA), .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
    .addr_out(addrA), .live_out(liveA), .bg_out(bgA), .active_out(activeA),
    .load_out(loadA), .frame_done(doneA));

  bg_stream_reader #(.ADDR_WIDTH(AW), .PIXEL_WIDTH(PW), .RAM_LAT(2), .FRAME_PIXELS(8)) dutB (
    .clk(clk), .rst(rst), .enable(enable), .frame_start(frameStart), .pix_valid(pixValid),
    .pix_data(pixData), .load_in(loadIn), .ram_rd_en(rdEnB), .ram_rd_addr(rdAddrB),
    .ram_rd_data(rdDataB), .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
    .addr_out(addrB), .live_out(liveB), .bg_out(bgB), .active_out(activeB),
    .load_out(loadB), .frame_done(doneB));

  // Two-cycle read-latency RAM holding a*3 at every address.
  always @(posedge clk) begin
    pipeA[0] <= rdEnA ? 16'(rdAddrA * 3) : 16'h0;
    pipeA[1] <= pipeA[0];
    pipeB[0] <= rdEnB ? 16'(rdAddrB * 3) : 16'h0;
    pipeB[1] <= pipeB[0];
  end
  assign rdDataA = pipeA[1];
  assign rdDataB = pipeB[1];

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    else passCount++;
  endtask

  // Inputs change just after the rising edge so the DUT sees them stable for the whole cycle.
  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    frameStart = v.fs;
    pixValid   = v.valid;
    enable     = v.en;
    loadIn     = v.load;
    pixData    = v.pix;
    wrEn       = v.wrEn;
    wrAddr     = v.wrAddr;
    wrData     = v.wrData;
  endtask

  task automatic checkOutput(input int row, input vec_t v);
    @(negedge clk);
    checkVal($sformatf("row%0d rd_en", row), 32'(rdEnA), 32'(v.expRdEn));
    if (v.expRdEn) checkVal($sformatf("row%0d rd_addr", row), 32'(rdAddrA), 32'(v.expRdAddr));
    checkVal($sformatf("row%0d active", row), 32'(activeA), 32'(v.expActive));
    checkVal($sformatf("row%0d addr", row), 32'(addrA), 32'(v.expAddr));
    checkVal($sformatf("row%0d live", row), 32'(liveA), 32'(v.expLive));
    checkVal($sformatf("row%0d bg", row), 32'(bgA), 32'(v.expBg));
    checkVal($sformatf("row%0d load", row), 32'(loadA), 32'(v.expLoad));
    checkVal($sformatf("row%0d done", row), 32'(doneA), 32'(v.expDone));
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, " rd_en"}, 32'(rdEnA), 0);
    checkVal({tag, " active"}, 32'(activeA), 0);
    checkVal({tag, " addr"}, 32'(addrA), 0);
    checkVal({tag, " live"}, 32'(liveA), 0);
    checkVal({tag, " bg"}, 32'(bgA), 0);
    checkVal({tag, " load"}, 32'(loadA), 0);
    checkVal({tag, " done"}, 32'(doneA), 0);
  endtask

  function automatic vec_t row(input logic fs, valid, en, load, input logic [PW-1:0] pix,
                               input logic rdEn, input logic [AW-1:0] rdAddr,
                               input logic act, input logic [AW-1:0] addr,
                               input logic [PW-1:0] live, bg, input logic ld, dn);
    vec_t v;
    v = '{fs, valid, en, load, pix, 1'b0, '0, '0, rdEn, rdAddr, act, addr, live, bg, ld, dn};
    return v;
  endfunction

  function automatic vec_t withWrite(input vec_t v, input logic [AW-1:0] a, input logic [PW-1:0] d);
    vec_t r;
    r = v;
    r.wrEn   = 1'b1;
    r.wrAddr = a;
    r.wrData = d;
    return r;
  endfunction

  initial begin
    vec_t idle;
    rst = 1'b1; enable = 1'b0; frameStart = 1'b0; pixValid = 1'b0; loadIn = 1'b0;
    pixData = '0; wrEn = 1'b0; wrAddr = '0; wrData = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAllZero("initial reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Frame of four, load on the second pixel, then hold behaviour while idle.
    vecs[0]  = row(1, 1, 1, 0, 16'hA000, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
    vecs[1]  = row(0, 1, 1, 1, 16'hA001, 1, 1, 0, 0, 16'h0000, 16'h0000, 0, 0);
    vecs[2]  = row(0, 1, 1, 0, 16'hA002, 1, 2, 1, 0, 16'hA000, 16'h0000, 0, 0);
    vecs[3]  = row(0, 1, 1, 0, 16'hA003, 1, 3, 1, 1, 16'hA001, 16'h0003, 1, 0);
    vecs[4]  = row(0, 0, 1, 0, 16'h0000, 0, 0, 1, 2, 16'hA002, 16'h0006, 0, 0);
    vecs[5]  = row(0, 0, 1, 0, 16'h0000, 0, 0, 1, 3, 16'hA003, 16'h0009, 0, 0);
    vecs[6]  = row(0, 0, 1, 0, 16'h0000, 0, 0, 0, 3, 16'hA003, 16'h0009, 0, 0);
    // Mid-frame frame_start: addresses 4,5 in flight finish unchanged, new pixel restarts at 0.
    vecs[7]  = row(0, 1, 1, 0, 16'hB004, 1, 4, 0, 3, 16'hA003, 16'h0009, 0, 0);
    vecs[8]  = row(0, 1, 1, 0, 16'hB005, 1, 5, 0, 3, 16'hA003, 16'h0009, 0, 0);
    vecs[9]  = row(1, 1, 1, 0, 16'hB006, 1, 0, 1, 4, 16'hB004, 16'h000C, 0, 0);
    vecs[10] = row(0, 1, 1, 0, 16'hB007, 1, 1, 1, 5, 16'hB005, 16'h000F, 0, 0);
    vecs[11] = row(0, 0, 1, 0, 16'h0000, 0, 0, 1, 0, 16'hB006, 16'h0000, 0, 0);
    vecs[12] = row(0, 0, 1, 0, 16'h0000, 0, 0, 1, 1, 16'hB007, 16'h0003, 0, 0);
    vecs[13] = row(0, 0, 1, 0, 16'h0000, 0, 0, 0, 1, 16'hB007, 16'h0003, 0, 0);
    // frame_start alone clears the counter; then enable=0 gates valid pixels for 5 cycles.
    vecs[14] = row(1, 0, 1, 0, 16'h0000, 0, 0, 0, 1, 16'hB007, 16'h0003, 0, 0);
    vecs[15] = row(0, 1, 1, 0, 16'hC000, 1, 0, 0, 1, 16'hB007, 16'h0003, 0, 0);
    vecs[16] = row(0, 1, 0, 0, 16'hC0FF, 0, 0, 0, 1, 16'hB007, 16'h0003, 0, 0);
    vecs[17] = row(0, 1, 0, 0, 16'hC0FF, 0, 0, 1, 0, 16'hC000, 16'h0000, 0, 0);
    vecs[18] = row(0, 1, 0, 0, 16'hC0FF, 0, 0, 0, 0, 16'hC000, 16'h0000, 0, 0);
    vecs[19] = row(0, 1, 0, 0, 16'hC0FF, 0, 0, 0, 0, 16'hC000, 16'h0000, 0, 0);
    vecs[20] = row(0, 1, 0, 0, 16'hC0FF, 0, 0, 0, 0, 16'hC000, 16'h0000, 0, 0);
    vecs[21] = row(0, 1, 1, 0, 16'hC001, 1, 1, 0, 0, 16'hC000, 16'h0000, 0, 0);
    vecs[22] = row(0, 0, 1, 0, 16'h0000, 0, 0, 0, 0, 16'hC000, 16'h0000, 0, 0);
    vecs[23] = row(0, 0, 1, 0, 16'h0000, 0, 0, 1, 1, 16'hC001, 16'h0003, 0, 0);
    // Forwarding: same-cycle write, overwrite by a later write, and no forward in output cycle.
    vecs[24] = withWrite(row(1, 1, 1, 0, 16'hE000, 1, 0, 0, 1, 16'hC001, 16'h0003, 0, 0), 0, 16'h1111);
    vecs[25] = withWrite(row(0, 1, 1, 0, 16'hE001, 1, 1, 0, 1, 16'hC001, 16'h0003, 0, 0), 0, 16'h2222);
    vecs[26] = withWrite(row(0, 1, 1, 0, 16'hE002, 1, 2, 1, 0, 16'hE000, 16'h2222, 0, 0), 1, 16'hABCD);
    vecs[27] = withWrite(row(0, 0, 1, 0, 16'h0000, 0, 0, 1, 1, 16'hE001, 16'hABCD, 0, 0), 2, 16'h5555);
    vecs[28] = withWrite(row(0, 0, 1, 0, 16'h0000, 0, 0, 1, 2, 16'hE002, 16'h5555, 0, 0), 2, 16'h7777);
    vecs[29] = row(0, 0, 1, 0, 16'h0000, 0, 0, 0, 2, 16'hE002, 16'h5555, 0, 0);

    for (int i = 0; i < 30; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i, vecs[i]);
    end

    // Address wrap: 66 back-to-back accepts; 64-pixel frame wraps after 63, 8-pixel after 7.
    idle = row(0, 0, 1, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
    for (int c = 0; c < 68; c++) begin
      vec_t v;
      v = idle;
      v.fs    = (c == 0);
      v.valid = (c < 66);
      v.pix   = 16'(16'h4000 + c);
      applyStimulus(v);
      @(negedge clk);
      if (c < 2) begin
        checkVal($sformatf("wrap c%0d activeA", c), 32'(activeA), 0);
      end else begin
        int k;
        k = c - 2;
        checkVal($sformatf("wrap k%0d activeA", k), 32'(activeA), 1);
        checkVal($sformatf("wrap k%0d addrA", k), 32'(addrA), 32'(k % 64));
        checkVal($sformatf("wrap k%0d doneA", k), 32'(doneA), 32'(k == 63));
        checkVal($sformatf("wrap k%0d liveA", k), 32'(liveA), 32'(16'h4000 + k));
        checkVal($sformatf("wrap k%0d addrB", k), 32'(addrB), 32'(k % 8));
        checkVal($sformatf("wrap k%0d doneB", k), 32'(doneB), 32'((k % 8) == 7));
        checkVal($sformatf("wrap k%0d bgB", k), 32'(bgB), 32'((k % 8) * 3));
      end
    end

    // Reset held three cycles while pixels are in flight; flushed pixels never emerge.
    for (int c = 0; c < 8; c++) begin
      vec_t v;
      v = idle;
      v.valid = (c < 5);
      v.pix   = 16'(16'h7000 + c);
      applyStimulus(v);
      rst = (c >= 2 && c <= 4);
      @(negedge clk);
      if (c == 2) checkVal("midreset c2 rd_en", 32'(rdEnA), 0);
      if (c == 3 || c == 4) checkAllZero($sformatf("midreset c%0d", c));
      if (c >= 5) begin
        checkVal($sformatf("postreset c%0d active", c), 32'(activeA), 0);
        checkVal($sformatf("postreset c%0d addr", c), 32'(addrA), 0);
        checkVal($sformatf("postreset c%0d live", c), 32'(liveA), 0);
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
